// File: rtl/modinv_controller.sv
// Sequences an extended binary GCD engine to compute e^-1 mod phi.
// Validates operands, runs the engine with a timeout, then folds the coefficient into [0,phi).
module modinv_controller #(
    parameter int WORD_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [WORD_WIDTH-1:0] req_e,
    input  logic [WORD_WIDTH-1:0] req_phi,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WORD_WIDTH-1:0] rsp_inv,
    output logic [1:0]            rsp_status,
    output logic                  gcd_rst_n,
    output logic                  gcd_enable,
    output logic [WORD_WIDTH-1:0] gcd_x,
    output logic [WORD_WIDTH-1:0] gcd_y,
    input  logic                  gcd_done,
    input  logic [WORD_WIDTH-1:0] gcd_result,
    input  logic [WORD_WIDTH-1:0] gcd_coeff_i
);
    localparam int W  = WORD_WIDTH;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

    localparam logic [1:0] ST_OK          = 2'd0;
    localparam logic [1:0] ST_NOT_COPRIME = 2'd1;
    localparam logic [1:0] ST_BAD_INPUT   = 2'd2;
    localparam logic [1:0] ST_TIMEOUT     = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK_IN, S_RST_ENG, S_START, S_WAIT, S_EVAL, S_NORM, S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [W-1:0]        e_q, e_d, phi_q, phi_d, res_q, res_d;
    logic [W-1:0]        gcd_x_q, gcd_x_d, gcd_y_q, gcd_y_d;
    logic [W-1:0]        rsp_inv_q, rsp_inv_d;
    logic [1:0]          status_q, status_d;
    logic [CW-1:0]       cnt_q, cnt_d, cnt_inc;
    logic signed [W:0]   acc_q, acc_d, phi_ext;
    logic                bad_in;

    always_comb begin
        state_d   = state_q;
        e_d       = e_q;
        phi_d     = phi_q;
        res_d     = res_q;
        gcd_x_d   = gcd_x_q;
        gcd_y_d   = gcd_y_q;
        rsp_inv_d = rsp_inv_q;
        status_d  = status_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        cnt_inc   = cnt_q + 1'b1;
        phi_ext   = $signed({1'b0, phi_q});
        // The engine treats operands as signed, so a set MSB is rejected too
        bad_in    = (e_q == '0) || (phi_q < W'(2)) || (e_q >= phi_q) || e_q[W-1] || phi_q[W-1];

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    e_d     = req_e;
                    phi_d   = req_phi;
                    state_d = S_CHECK_IN;
                end
            end
            S_CHECK_IN: begin
                if (bad_in) begin
                    status_d  = ST_BAD_INPUT;
                    rsp_inv_d = '0;
                    state_d   = S_RESP;
                end else begin
                    gcd_x_d = e_q;
                    gcd_y_d = phi_q;
                    state_d = S_RST_ENG;
                end
            end
            S_RST_ENG: state_d = S_START;
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_inc;
                if (gcd_done) begin
                    res_d   = gcd_result;
                    acc_d   = $signed({gcd_coeff_i[W-1], gcd_coeff_i});
                    state_d = S_EVAL;
                end else if (cnt_inc == TMO) begin
                    status_d  = ST_TIMEOUT;
                    rsp_inv_d = '0;
                    state_d   = S_RESP;
                end
            end
            S_EVAL: begin
                if (res_q != W'(1)) begin
                    status_d  = ST_NOT_COPRIME;
                    rsp_inv_d = '0;
                    state_d   = S_RESP;
                end else begin
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                // One fold toward [0,phi) per cycle; the extra sign bit keeps this overflow-free
                if (acc_q[W]) begin
                    acc_d = acc_q + phi_ext;
                end else if (acc_q >= phi_ext) begin
                    acc_d = acc_q - phi_ext;
                end else begin
                    rsp_inv_d = acc_q[W-1:0];
                    status_d  = ST_OK;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            gcd_x_q   <= '0;
            gcd_y_q   <= '0;
            rsp_inv_q <= '0;
            status_q  <= ST_OK;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            gcd_x_q   <= gcd_x_d;
            gcd_y_q   <= gcd_y_d;
            rsp_inv_q <= rsp_inv_d;
            status_q  <= status_d;
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        e_q   <= e_d;
        phi_q <= phi_d;
        res_q <= res_d;
        acc_q <= acc_d;
    end

    assign req_ready  = (state_q == S_IDLE);
    assign rsp_valid  = (state_q == S_RESP);
    assign gcd_rst_n  = (state_q == S_START) || (state_q == S_WAIT);
    assign gcd_enable = (state_q == S_START) || (state_q == S_WAIT);
    assign gcd_x      = gcd_x_q;
    assign gcd_y      = gcd_y_q;
    assign rsp_inv    = rsp_inv_q;
    assign rsp_status = status_q;

endmodule

// File: tb/tb_modinv_controller.sv
// Bench for modinv_controller: behavioural GCD engine plus a scoreboard of expected responses.
module tb_modinv_controller;
    localparam int W   = 32;
    localparam int TMO = 64;

    logic         clk = 1'b0;
    logic         reset, req_valid, req_ready, rsp_valid, rsp_ready;
    logic [W-1:0] req_e, req_phi, rsp_inv, gcd_x, gcd_y, gcd_result, gcd_coeff_i;
    logic [1:0]   rsp_status;
    logic         gcd_rst_n, gcd_enable, gcd_done;

    modinv_controller #(.WORD_WIDTH(W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_e(req_e), .req_phi(req_phi),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_inv(rsp_inv), .rsp_status(rsp_status),
        .gcd_rst_n(gcd_rst_n), .gcd_enable(gcd_enable), .gcd_x(gcd_x), .gcd_y(gcd_y),
        .gcd_done(gcd_done), .gcd_result(gcd_result), .gcd_coeff_i(gcd_coeff_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   st;
        logic [W-1:0] inv;
        int           lat;
    } exp_t;

    exp_t         sb[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    int           en_cnt  = 0;
    int           eng_lat = 0;
    int           eng_m   = 0;
    int           eng_hang = 0;
    logic [W-1:0] last_inv;

    function automatic longint egcd(input longint a, input longint b, input bit want_g);
        longint r0 = a, r1 = b, s0 = 1, s1 = 0, q, t;
        while (r1 != 0) begin
            q = r0 / r1;
            t = r1; r1 = r0 - q * r1; r0 = t;
            t = s1; s1 = s0 - q * s1; s0 = t;
        end
        return want_g ? r0 : s0;
    endfunction

    // Behavioural engine: samples x,y while held in reset, reports done eng_lat cycles after enable
    logic [W-1:0] m_x, m_y;
    int           m_cnt;
    always @(posedge clk) begin
        if (!gcd_rst_n) begin
            m_x      <= gcd_x;
            m_y      <= gcd_y;
            m_cnt    <= 0;
            gcd_done <= 1'b0;
        end else if (gcd_enable && !gcd_done && eng_hang == 0) begin
            if (m_cnt == eng_lat) begin
                gcd_done    <= 1'b1;
                gcd_result  <= W'(egcd(longint'(m_x), longint'(m_y), 1'b1));
                gcd_coeff_i <= W'(egcd(longint'(m_x), longint'(m_y), 1'b0)
                                  + longint'(eng_m) * longint'(m_y));
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    always @(posedge clk) if (gcd_enable) en_cnt <= en_cnt + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run(input logic [W-1:0] e, input logic [W-1:0] phi, input int lat_e,
                       input int m, input int hang, input int hold, input int early);
        exp_t   x, y;
        longint pl, c, steps;
        int     cyc, en0;
        pl = longint'(phi);
        eng_lat = lat_e; eng_m = m; eng_hang = hang;
        x.inv = '0;
        if (e == 0 || phi < 2 || e >= phi || e[W-1] || phi[W-1]) begin
            x.st = 2'd2; x.lat = 1;
        end else if (hang != 0) begin
            x.st = 2'd3; x.lat = 3 + TMO;
        end else if (egcd(longint'(e), pl, 1'b1) != 1) begin
            x.st = 2'd1; x.lat = 4 + lat_e + 1;
        end else begin
            c     = egcd(longint'(e), pl, 1'b0) + longint'(m) * pl;
            steps = (c < 0) ? (-c + pl - 1) / pl : c / pl;
            x.st  = 2'd0;
            x.inv = W'(((c % pl) + pl) % pl);
            x.lat = 5 + lat_e + 1 + int'(steps);
        end
        sb.push_back(x);

        en0 = en_cnt;
        rsp_ready = (early != 0);
        req_e = e; req_phi = phi; req_valid = 1'b1;
        check("req_ready_idle", req_ready, 1);
        @(posedge clk); #1;
        // Keep a bogus request pending while busy; it must not be taken
        req_e = '0; req_phi = '0;
        cyc = 0;
        while (!rsp_valid && cyc < 400) begin
            check("req_ready_busy", req_ready, 0);
            @(posedge clk); #1;
            cyc++;
            if (x.st != 2'd2 && cyc == 1) begin
                check("rst_eng_rst_n", gcd_rst_n, 0);
                check("rst_eng_enable", gcd_enable, 0);
                check("rst_eng_x", gcd_x, e);
                check("rst_eng_y", gcd_y, phi);
            end
            if (x.st != 2'd2 && cyc == 2) begin
                check("start_rst_n", gcd_rst_n, 1);
                check("start_enable", gcd_enable, 1);
            end
        end
        req_valid = 1'b0;
        check("rsp_latency", cyc, x.lat);
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", rsp_valid, 1);
            check("hold_status", rsp_status, x.st);
            check("hold_inv", rsp_inv, x.inv);
            @(posedge clk); #1;
        end
        y = sb.pop_front();
        check("rsp_status", rsp_status, y.st);
        check("rsp_inv", rsp_inv, y.inv);
        last_inv = rsp_inv;
        if (y.st == 2'd2) check("bad_no_enable", en_cnt - en0, 0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("post_rsp_valid", rsp_valid, 0);
        check("post_req_ready", req_ready, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; req_e = '0; req_phi = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_inv", rsp_inv, 0);
        check("rst_rsp_status", rsp_status, 0);
        check("rst_gcd_rst_n", gcd_rst_n, 0);
        check("rst_gcd_enable", gcd_enable, 0);
        check("rst_gcd_x", gcd_x, 0);
        check("rst_gcd_y", gcd_y, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        run(3, 20, 2, 0, 0, 0, 0);
        check("inv_3_20", last_inv, 7);
        run(3, 20, 0, 2, 0, 10, 0);
        run(3, 20, 5, -3, 0, 0, 1);
        run(17, 3120, 3, 0, 0, 0, 0);
        check("inv_17_3120", last_inv, 2753);
        check("prod_17_mod", (longint'(17) * longint'(last_inv)) % 3120, 1);
        run(17, 3120, 1, -1, 0, 3, 0);
        run(4, 10, 2, 0, 0, 0, 0);
        run(0, 20, 0, 0, 0, 0, 0);
        run(25, 20, 0, 0, 0, 0, 0);
        run(20, 20, 0, 0, 0, 0, 0);
        run(1, 1, 0, 0, 0, 0, 0);
        run(32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
        run(3, 32'h8000_0003, 0, 0, 0, 0, 0);
        run(7, 40, 0, 0, 1, 2, 0);
        // Done arrives on the last allowed WAIT cycle, so it must win over the timeout
        run(7, 40, TMO - 1, 1, 0, 0, 0);

        eng_hang = 1;
        req_e = 3; req_phi = 20; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("wait_enable", gcd_enable, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst_req_ready", req_ready, 1);
        check("midrst_gcd_rst_n", gcd_rst_n, 0);
        check("midrst_enable", gcd_enable, 0);
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_gcd_x", gcd_x, 0);
        eng_hang = 0;
        @(posedge clk); #1;
        run(3, 20, 1, 1, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
